// File: rtl/display_capture.sv
// display_capture: loop-back decoder for the 4-digit multiplexed 7-segment scan.
// Rebuilds HEX/SPR frames from sampled anode strobes and segment lines.
module display_capture #(
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   slow_clock,
    input  logic                   RESET,
    input  logic [6:0]             segs,
    input  logic [3:0]             an,
    output logic [7:0]             hex_value,
    output logic [6:0]             spr_value,
    output logic                   frame_valid,
    output logic                   value_changed,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   seg_error,
    output logic                   seq_error,
    output logic                   range_error
);

    // EXP0 is the post-publish state: digit 0 must follow, unlike SYNC
    typedef enum logic [2:0] {SYNC, EXP0, EXP1, EXP2, EXP3} state_t;

    state_t     state;
    state_t     state_nx;
    logic       seg_ok;
    logic [3:0] seg_nib;
    logic       an_ok;
    logic [3:0] exp_an;
    logic [2:0] take;
    logic       publish;
    logic       set_seg;
    logic       set_seq;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic       seen;
    logic [7:0] new_hex;
    logic [6:0] new_spr;

    // Segment pattern (active-low, a..g) back to a nibble
    always_comb begin
        seg_ok  = 1'b1;
        seg_nib = 4'h0;
        case (segs)
            7'b0000001: seg_nib = 4'h0;
            7'b1001111: seg_nib = 4'h1;
            7'b0010010: seg_nib = 4'h2;
            7'b0000110: seg_nib = 4'h3;
            7'b1001100: seg_nib = 4'h4;
            7'b0100100: seg_nib = 4'h5;
            7'b0100000: seg_nib = 4'h6;
            7'b0001111: seg_nib = 4'h7;
            7'b0000000: seg_nib = 4'h8;
            7'b0000100: seg_nib = 4'h9;
            7'b0001000: seg_nib = 4'hA;
            7'b1100000: seg_nib = 4'hB;
            7'b0110001: seg_nib = 4'hC;
            7'b1000010: seg_nib = 4'hD;
            7'b0110000: seg_nib = 4'hE;
            7'b0111000: seg_nib = 4'hF;
            default:    seg_ok  = 1'b0;
        endcase
    end

    assign an_ok   = $onehot(~an);
    assign new_hex = {dig1, dig0};
    assign new_spr = {seg_nib[2:0], dig2};

    // State register
    always_ff @(posedge slow_clock) begin
        if (RESET) state <= SYNC;
        else       state <= state_nx;
    end

    // Next state, digit strobes and error requests
    always_comb begin
        state_nx = state;
        take     = 3'b000;
        publish  = 1'b0;
        set_seg  = !seg_ok;
        set_seq  = 1'b0;
        exp_an   = 4'b1110;
        unique case (state)
            SYNC, EXP0: exp_an = 4'b1110;
            EXP1:       exp_an = 4'b1101;
            EXP2:       exp_an = 4'b1011;
            EXP3:       exp_an = 4'b0111;
            default:    exp_an = 4'b1110;
        endcase
        if (state == SYNC) begin
            set_seq = !an_ok;
            if (an == exp_an && seg_ok) begin
                take[0]  = 1'b1;
                state_nx = EXP1;
            end
        end else if (an != exp_an || !seg_ok) begin
            set_seq  = (an != exp_an);
            state_nx = SYNC;
        end else begin
            unique case (state)
                EXP0: begin take[0] = 1'b1; state_nx = EXP1; end
                EXP1: begin take[1] = 1'b1; state_nx = EXP2; end
                EXP2: begin take[2] = 1'b1; state_nx = EXP3; end
                EXP3: begin publish = 1'b1; state_nx = EXP0; end
                default: state_nx = SYNC;
            endcase
        end
    end

    // Digit capture, frame publish and sticky error flags
    always_ff @(posedge slow_clock) begin
        if (RESET) begin
            dig0          <= '0;
            dig1          <= '0;
            dig2          <= '0;
            seen          <= 1'b0;
            hex_value     <= '0;
            spr_value     <= '0;
            frame_valid   <= 1'b0;
            value_changed <= 1'b0;
            frame_count   <= '0;
            seg_error     <= 1'b0;
            seq_error     <= 1'b0;
            range_error   <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            value_changed <= 1'b0;
            if (set_seg) seg_error <= 1'b1;
            if (set_seq) seq_error <= 1'b1;
            if (take[0]) dig0 <= seg_nib;
            if (take[1]) dig1 <= seg_nib;
            if (take[2]) dig2 <= seg_nib;
            if (publish) begin
                hex_value     <= new_hex;
                spr_value     <= new_spr;
                frame_valid   <= 1'b1;
                frame_count   <= frame_count + 1'b1;
                value_changed <= seen &&
                    ({new_hex, new_spr} != {hex_value, spr_value});
                seen          <= 1'b1;
                if (seg_nib[3]) range_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_capture.sv
// tb_display_capture: directed checks of frame decode, sequencing and errors.
// A second instance with a 2-bit frame counter exercises counter wrap.
module tb_display_capture;

    logic       slow_clock = 1'b0;
    logic       RESET = 1'b1;
    logic [6:0] segs = 7'h7F;
    logic [3:0] an = 4'hF;

    logic [7:0] hex_value;
    logic [6:0] spr_value;
    logic       frame_valid;
    logic       value_changed;
    logic [7:0] frame_count;
    logic       seg_error;
    logic       seq_error;
    logic       range_error;

    logic [7:0] s_hex;
    logic [6:0] s_spr;
    logic       s_fv;
    logic       s_vc;
    logic [1:0] s_fc;
    logic       s_sege;
    logic       s_seqe;
    logic       s_rnge;

    int errors = 0;
    int checks = 0;

    logic [6:0] enc [16];

    display_capture #(.FRAME_CNT_W(8)) dut (
        .slow_clock(slow_clock), .RESET(RESET),
        .segs(segs), .an(an),
        .hex_value(hex_value), .spr_value(spr_value),
        .frame_valid(frame_valid), .value_changed(value_changed),
        .frame_count(frame_count), .seg_error(seg_error),
        .seq_error(seq_error), .range_error(range_error)
    );

    display_capture #(.FRAME_CNT_W(2)) dut_small (
        .slow_clock(slow_clock), .RESET(RESET),
        .segs(segs), .an(an),
        .hex_value(s_hex), .spr_value(s_spr),
        .frame_valid(s_fv), .value_changed(s_vc),
        .frame_count(s_fc), .seg_error(s_sege),
        .seq_error(s_seqe), .range_error(s_rnge)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        an   = a;
        segs = s;
        @(posedge slow_clock);
        #1;
    endtask

    task automatic dig(input int d, input logic [3:0] n);
        logic [3:0] a;
        a = 4'hF;
        a[d] = 1'b0;
        drive(a, enc[n]);
    endtask

    task automatic frame(input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3);
        dig(0, d0);
        dig(1, d1);
        dig(2, d2);
        dig(3, d3);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        drive(4'hF, 7'h7F);
        RESET = 1'b0;
    endtask

    initial begin
        enc[0]  = 7'b0000001; enc[1]  = 7'b1001111;
        enc[2]  = 7'b0010010; enc[3]  = 7'b0000110;
        enc[4]  = 7'b1001100; enc[5]  = 7'b0100100;
        enc[6]  = 7'b0100000; enc[7]  = 7'b0001111;
        enc[8]  = 7'b0000000; enc[9]  = 7'b0000100;
        enc[10] = 7'b0001000; enc[11] = 7'b1100000;
        enc[12] = 7'b0110001; enc[13] = 7'b1000010;
        enc[14] = 7'b0110000; enc[15] = 7'b0111000;

        // reset state
        do_reset();
        chk("rst_hex", hex_value, 0);
        chk("rst_spr", spr_value, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_err", {seg_error, seq_error, range_error}, 0);

        // clean frame 5 A 3 6
        frame(4'h5, 4'hA, 4'h3, 4'h6);
        chk("t1_hex", hex_value, 8'hA5);
        chk("t1_spr", spr_value, 7'h63);
        chk("t1_fv", frame_valid, 1);
        chk("t1_vc", value_changed, 0);
        chk("t1_fc", frame_count, 1);
        chk("t1_err", {seg_error, seq_error, range_error}, 0);
        dig(0, 4'h5);
        chk("t1_fv_drop", frame_valid, 0);

        // scan acquired mid-way at digit 2
        do_reset();
        dig(2, 4'h3);
        dig(3, 4'h6);
        chk("t2_nopub", frame_count, 0);
        dig(0, 4'h5);
        dig(1, 4'hA);
        dig(2, 4'h3);
        chk("t2_before", frame_count, 0);
        dig(3, 4'h6);
        chk("t2_fc", frame_count, 1);
        chk("t2_hex", hex_value, 8'hA5);
        chk("t2_err", {seg_error, seq_error, range_error}, 0);

        // digit 2 skipped
        do_reset();
        dig(0, 4'h1);
        dig(1, 4'h2);
        dig(3, 4'h4);
        chk("t3_seq", seq_error, 1);
        chk("t3_nopub", frame_count, 0);
        frame(4'h7, 4'h8, 4'h9, 4'h2);
        chk("t3_fc", frame_count, 1);
        chk("t3_hex", hex_value, 8'h87);
        chk("t3_spr", spr_value, 7'h29);
        chk("t3_seq_sticky", seq_error, 1);

        // blank pattern on digit 1
        do_reset();
        dig(0, 4'h5);
        drive(4'b1101, 7'b1111111);
        chk("t4_seg", seg_error, 1);
        chk("t4_seq", seq_error, 0);
        dig(2, 4'h1);
        chk("t4_sync_silent", seq_error, 0);
        chk("t4_nopub", frame_count, 0);
        frame(4'hC, 4'hB, 4'hE, 4'h1);
        chk("t4_hex", hex_value, 8'hBC);
        chk("t4_spr", spr_value, 7'h1E);
        chk("t4_fc", frame_count, 1);

        // value_changed over three frames
        do_reset();
        frame(4'h5, 4'hA, 4'h3, 4'h6);
        chk("t5_vc1", value_changed, 0);
        frame(4'h5, 4'hA, 4'h3, 4'h6);
        chk("t5_fv2", frame_valid, 1);
        chk("t5_vc2", value_changed, 0);
        frame(4'h6, 4'hA, 4'h3, 4'h6);
        chk("t5_vc3", value_changed, 1);
        chk("t5_hex", hex_value, 8'hA6);
        chk("t5_fc", frame_count, 3);
        chk("t5_err", {seg_error, seq_error, range_error}, 0);

        // digit 3 out of range
        do_reset();
        frame(4'h1, 4'h2, 4'h0, 4'hF);
        chk("t6_spr", spr_value, 7'h70);
        chk("t6_hex", hex_value, 8'h21);
        chk("t6_rng", range_error, 1);
        chk("t6_fc", frame_count, 1);

        // reset during EXP2
        do_reset();
        frame(4'h4, 4'h9, 4'h2, 4'h3);
        dig(0, 4'h1);
        dig(1, 4'h2);
        RESET = 1'b1;
        dig(2, 4'h3);
        RESET = 1'b0;
        chk("t7_hex", hex_value, 0);
        chk("t7_spr", spr_value, 0);
        chk("t7_fc", frame_count, 0);
        chk("t7_fv", frame_valid, 0);
        dig(3, 4'h4);
        chk("t7_nopub", {frame_valid, frame_count}, 0);
        frame(4'hD, 4'h0, 4'h8, 4'h5);
        chk("t7_fc", frame_count, 1);
        chk("t7_hex2", hex_value, 8'h0D);
        chk("t7_spr2", spr_value, 7'h58);

        // 2-bit frame counter wrap
        do_reset();
        frame(4'h0, 4'h1, 4'h2, 4'h3);
        chk("t8_fc1", s_fc, 1);
        frame(4'h0, 4'h1, 4'h2, 4'h3);
        chk("t8_fc2", s_fc, 2);
        frame(4'h0, 4'h1, 4'h2, 4'h3);
        chk("t8_fc3", s_fc, 3);
        frame(4'h0, 4'h1, 4'h2, 4'h3);
        chk("t8_fc0", s_fc, 0);
        frame(4'h0, 4'h1, 4'h2, 4'h3);
        chk("t8_fc1b", s_fc, 1);
        chk("t8_fc_wide", frame_count, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
